ioctl_rom_router: RTL and testbench

IOCTL_ROM_ROUTER -- requirements
Module: ioctl_rom_router

---
 rtl/rom_router_pkg.sv | 26 ++
 rtl/rom_port_map.sv | 89 ++++++++
 rtl/ioctl_rom_router.sv | 109 ++++++++++
 tb/tb_ioctl_rom_router.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_router_pkg.sv
// Shared definitions for the ioctl ROM router.
//   port_mode_e : how a port turns a byte offset into an SDRAM word address
//   LANE_W/NUM_LANES/WORD_W : byte lane and SDRAM word geometry
//   WADDR_W : SDRAM word address width per port
//   OFF_W   : byte-offset bits a port can address (word address + lane bit)
//   CNT_W   : width of the second-reset delay counter
//   lane_sel() : one-hot {hi,lo} byte-lane select from the lane bit
package rom_router_pkg;

  typedef enum logic {
    LINEAR      = 1'b0,  // 16-bit linear image
    INTERLEAVED = 1'b1   // 32-bit image split into two 64 KB halves
  } port_mode_e;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = 2;
  localparam int unsigned WORD_W    = LANE_W * NUM_LANES;
  localparam int unsigned WADDR_W   = 23;
  localparam int unsigned OFF_W     = WADDR_W + 1;
  localparam int unsigned CNT_W     = 16;

  function automatic logic [NUM_LANES-1:0] lane_sel(input logic hi);
    return {hi, ~hi};
  endfunction

endpackage

// File: rtl/rom_port_map.sv
// One SDRAM write port of the ioctl ROM router: decodes whether a download byte
// falls in this port's region, maps it to a word address / lane select and
// issues it over a toggle request/acknowledge handshake.
// Ports:
//   clk_sys, reset      : system clock, asynchronous active-high reset
//   wr_event            : single-cycle qualified byte-write event
//   ioctl_addr          : byte address of the download
//   ioctl_dout          : byte data of the download
//   ack                 : toggle acknowledge from the SDRAM controller
//   req                 : toggle request (idle when req == ack)
//   a, ds, d            : word address, {hi,lo} lane select, duplicated data
//   overrun             : sticky, set when a byte arrived while busy
module rom_port_map import rom_router_pkg::*; #(
  parameter int unsigned     AW    = 25,
  parameter logic [AW-1:0]   BASE  = '0,
  parameter logic [AW-1:0]   LIMIT = '1,
  parameter port_mode_e      MODE  = LINEAR
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               wr_event,
  input  logic [AW-1:0]      ioctl_addr,
  input  logic [LANE_W-1:0]  ioctl_dout,
  input  logic               ack,
  output logic               req,
  output logic [WADDR_W-1:0] a,
  output logic [1:0]         ds,
  output logic [WORD_W-1:0]  d,
  output logic               overrun
);

  logic               hit;
  logic               idle;
  logic [OFF_W-1:0]   off;
  logic [WADDR_W-1:0] a_d;
  logic [1:0]         ds_d;

  logic               req_q;
  logic [WADDR_W-1:0] a_q;
  logic [1:0]         ds_q;
  logic [WORD_W-1:0]  d_q;
  logic               overrun_q;

  assign hit  = (ioctl_addr >= BASE) && (ioctl_addr <= LIMIT);
  assign idle = (req_q == ack);
  // Only meaningful when hit, so the subtraction never wraps in use.
  assign off  = OFF_W'(ioctl_addr - BASE);

  always_comb begin
    a_d  = '0;
    ds_d = '0;
    if (MODE == INTERLEAVED) begin
      // Bit 16 picks the 64 KB half, which becomes the word's low address bit,
      // so the two halves land in alternating words of a 32-bit layout.
      a_d  = WADDR_W'({off[14:0], off[16]});
      ds_d = lane_sel(off[15]);
    end else begin
      a_d  = off[OFF_W-1:1];
      ds_d = lane_sel(off[0]);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      req_q     <= 1'b0;
      a_q       <= '0;
      ds_q      <= '0;
      d_q       <= '0;
      overrun_q <= 1'b0;
    end else if (wr_event && hit) begin
      if (idle) begin
        a_q   <= a_d;
        ds_q  <= ds_d;
        d_q   <= {ioctl_dout, ioctl_dout};
        req_q <= ~req_q;
      end else begin
        // Previous word still in flight: drop this byte, flag it forever.
        overrun_q <= 1'b1;
      end
    end
  end

  assign req     = req_q;
  assign a       = a_q;
  assign ds      = ds_q;
  assign d       = d_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/ioctl_rom_router.sv
// Routes bytes from the ioctl download stream into up to four SDRAM write
// ports, each owning an address region, and sequences the core reset around
// the ROM load (held until the first download completes, then one extra
// one-cycle pulse RST_CNT-1 cycles after every release).
// Ports:
//   clk_sys, reset      : system clock, asynchronous active-high reset
//   ioctl_download      : download in progress
//   ioctl_wr            : byte strobe, rising edge significant
//   ioctl_addr          : byte address
//   ioctl_dout          : byte data
//   user_reset          : menu/button reset request
//   port_req / port_ack : per-port toggle handshake with the SDRAM
//   port_a/port_ds/port_d : per-port word address, lane select, data
//   overrun             : per-port sticky dropped-write flag
//   rom_loaded          : set once the first download has completed
//   core_reset          : reset to the game core
module ioctl_rom_router import rom_router_pkg::*; #(
  parameter int unsigned            NPORTS  = 2,
  parameter int unsigned            AW      = 25,
  parameter logic [NPORTS*AW-1:0]   BASE    = {25'h11000, 25'h0},
  parameter logic [NPORTS*AW-1:0]   LIMIT   = {25'h1FFFFFF, 25'h1FFFFFF},
  parameter logic [NPORTS-1:0]      MODE    = 2'b10,
  parameter logic [CNT_W-1:0]       RST_CNT = 16'hFFFF
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        ioctl_download,
  input  logic                        ioctl_wr,
  input  logic [AW-1:0]               ioctl_addr,
  input  logic [LANE_W-1:0]           ioctl_dout,
  input  logic                        user_reset,
  output logic [NPORTS-1:0]           port_req,
  input  logic [NPORTS-1:0]           port_ack,
  output logic [NPORTS*WADDR_W-1:0]   port_a,
  output logic [NPORTS*2-1:0]         port_ds,
  output logic [NPORTS*WORD_W-1:0]    port_d,
  output logic [NPORTS-1:0]           overrun,
  output logic                        rom_loaded,
  output logic                        core_reset
);

  logic             wr_last_q;
  logic             dl_last_q;
  logic             rom_loaded_q, rom_loaded_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_reset_q, core_reset_d;

  logic             wr_event;
  logic             dl_fall;
  logic             hold_reset;

  assign wr_event   = ioctl_wr & ~wr_last_q & ioctl_download;
  assign dl_fall    = dl_last_q & ~ioctl_download;
  assign hold_reset = user_reset | ~rom_loaded_q;

  always_comb begin
    rom_loaded_d = rom_loaded_q | dl_fall;
    cnt_d        = cnt_q;
    if (hold_reset) begin
      cnt_d = RST_CNT;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // Counter passing through 1 yields the single delayed second pulse.
    core_reset_d = hold_reset | (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_last_q    <= 1'b0;
      dl_last_q    <= 1'b0;
      rom_loaded_q <= 1'b0;
      cnt_q        <= RST_CNT;
      core_reset_q <= 1'b1;
    end else begin
      wr_last_q    <= ioctl_wr;
      dl_last_q    <= ioctl_download;
      rom_loaded_q <= rom_loaded_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;

  // Ports decode independently, so overlapping regions all receive the byte.
  for (genvar p = 0; p < NPORTS; p++) begin : gen_port
    rom_port_map #(
      .AW    (AW),
      .BASE  (BASE[p*AW +: AW]),
      .LIMIT (LIMIT[p*AW +: AW]),
      .MODE  (port_mode_e'(MODE[p]))
    ) u_map (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .wr_event   (wr_event),
      .ioctl_addr (ioctl_addr),
      .ioctl_dout (ioctl_dout),
      .ack        (port_ack[p]),
      .req        (port_req[p]),
      .a          (port_a[p*WADDR_W +: WADDR_W]),
      .ds         (port_ds[p*2 +: 2]),
      .d          (port_d[p*WORD_W +: WORD_W]),
      .overrun    (overrun[p])
    );
  end

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Scoreboard bench for ioctl_rom_router: stimulus pushes the expected word per
// port, a monitor pops and compares on every port_req toggle.
module tb_ioctl_rom_router;

  localparam int NP = 2;
  localparam int AW = 25;
  localparam int RC = 16;
  localparam logic [NP*AW-1:0] TB_BASE  = {25'h11000, 25'h0};
  localparam logic [NP*AW-1:0] TB_LIMIT = {25'h0FFFFFF, 25'h01FFFFF};
  localparam logic [NP-1:0]    TB_MODE  = 2'b10;

  // Same regions stated per port for the reference model.
  int unsigned base_a  [NP] = '{32'h0, 32'h11000};
  int unsigned limit_a [NP] = '{32'h1FFFFF, 32'hFFFFFF};
  int unsigned mode_a  [NP] = '{0, 1};

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_item_t;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic             ioctl_download;
  logic             ioctl_wr;
  logic [AW-1:0]    ioctl_addr;
  logic [7:0]       ioctl_dout;
  logic             user_reset;
  logic [NP-1:0]    port_req;
  logic [NP-1:0]    port_ack;
  logic [NP*23-1:0] port_a;
  logic [NP*2-1:0]  port_ds;
  logic [NP*16-1:0] port_d;
  logic [NP-1:0]    overrun;
  logic             rom_loaded;
  logic             core_reset;

  int total = 0;
  int bad   = 0;

  exp_item_t     expq [NP][$];
  logic [NP-1:0] exp_req;
  logic [NP-1:0] exp_ovr;
  logic [NP-1:0] hold;
  logic [NP-1:0] mon_prev;

  ioctl_rom_router #(
    .NPORTS  (NP),
    .AW      (AW),
    .BASE    (TB_BASE),
    .LIMIT   (TB_LIMIT),
    .MODE    (TB_MODE),
    .RST_CNT (16'(RC))
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .user_reset     (user_reset),
    .port_req       (port_req),
    .port_ack       (port_ack),
    .port_a         (port_a),
    .port_ds        (port_ds),
    .port_d         (port_d),
    .overrun        (overrun),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic exp_item_t model_map(input int p, input int unsigned addr,
                                          input logic [7:0] dat);
    exp_item_t   it;
    int unsigned off;
    off = addr - base_a[p];
    if (mode_a[p] == 0) begin
      it.a  = 23'(off / 2);
      it.ds = (off % 2 != 0) ? 2'b10 : 2'b01;
    end else begin
      it.a  = 23'((off % 32768) * 2 + (off / 65536) % 2);
      it.ds = ((off / 32768) % 2 != 0) ? 2'b10 : 2'b01;
    end
    it.d = {dat, dat};
    return it;
  endfunction

  // Called in the event cycle, just before the edge where the DUT acts.
  task automatic model_event(input int unsigned addr, input logic [7:0] dat);
    if (!ioctl_download) return;
    for (int p = 0; p < NP; p++) begin
      if (addr >= base_a[p] && addr <= limit_a[p]) begin
        if (exp_req[p] == port_ack[p]) begin
          expq[p].push_back(model_map(p, addr, dat));
          exp_req[p] = ~exp_req[p];
        end else begin
          exp_ovr[p] = 1'b1;
        end
      end
    end
  endtask

  task automatic do_write(input int unsigned addr, input logic [7:0] dat);
    @(posedge clk_sys); #1;
    ioctl_addr = AW'(addr);
    ioctl_dout = dat;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    model_event(addr, dat);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0 || port_req !== port_ack) && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    check({name, "_q0_empty"}, 64'(expq[0].size()), 64'd0);
    check({name, "_q1_empty"}, 64'(expq[1].size()), 64'd0);
    check({name, "_req"}, 64'(port_req), 64'(exp_req));
  endtask

  task automatic model_clear();
    exp_req = '0;
    exp_ovr = '0;
    for (int p = 0; p < NP; p++) expq[p].delete();
  endtask

  // SDRAM responder: acknowledges outstanding requests after a random delay.
  initial begin
    port_ack = '0;
    forever begin
      @(posedge clk_sys); #1;
      if (!reset) begin
        for (int p = 0; p < NP; p++) begin
          if (!hold[p] && port_req[p] !== port_ack[p] && $urandom_range(0, 2) != 0)
            port_ack[p] = port_req[p];
        end
      end
    end
  end

  // Monitor: every request toggle must match the oldest expected word.
  initial begin
    mon_prev = '0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        mon_prev = port_req;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (port_req[p] !== mon_prev[p]) begin
            mon_prev[p] = port_req[p];
            if (expq[p].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_req port%0d: got toggle, expected none", p);
            end else begin
              exp_item_t it;
              it = expq[p].pop_front();
              check($sformatf("port%0d_a", p), 64'(port_a[p*23 +: 23]), 64'(it.a));
              check($sformatf("port%0d_ds", p), 64'(port_ds[p*2 +: 2]), 64'(it.ds));
              check($sformatf("port%0d_d", p), 64'(port_d[p*16 +: 16]), 64'(it.d));
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   bnd [6] = '{32'h10FFF, 32'h11000, 32'h1FFFFF, 32'h200000, 32'hFFFFFF,
                               32'h1000000};
    logic [31:0]   got_v, exp_v;
    logic [NP*23-1:0] a_snap;
    int unsigned   addr;
    int            k;

    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; user_reset = 1'b0; hold = '0;
    model_clear();
    repeat (2) @(negedge clk_sys);
    check("rst_req", 64'(port_req), 64'd0);
    check("rst_a", 64'(port_a), 64'd0);
    check("rst_ds", 64'(port_ds), 64'd0);
    check("rst_d", 64'(port_d), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_rom_loaded", 64'(rom_loaded), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    @(posedge clk_sys); #1;
    reset = 1'b0;

    // Directed bytes from the worked examples.
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    do_write(32'h3, 8'hA5);
    drain("ex_linear");
    do_write(32'h11000 + 32'h18002, 8'h5C);
    drain("ex_interleaved");

    // Two bytes three cycles apart while port 0 withholds its ack.
    hold[0] = 1'b1;
    do_write(32'h100, 8'h11);
    @(posedge clk_sys);
    do_write(32'h102, 8'h22);
    @(negedge clk_sys);
    check("ovr_flag", 64'(overrun[0]), 64'd1);
    check("ovr_a_kept", 64'(port_a[22:0]), 64'h80);
    @(posedge clk_sys); #1;
    hold[0] = 1'b0;
    drain("ovr");

    // Randomised download across both regions, their edges and unmapped space.
    for (int i = 0; i < 150; i++) begin
      k = int'($urandom_range(0, 9));
      if (k <= 3)      addr = $urandom_range(0, 32'h10FFF);
      else if (k <= 6) addr = $urandom_range(32'h11000, 32'h1FFFFF);
      else if (k == 7) addr = $urandom_range(32'h200000, 32'hFFFFFF);
      else if (k == 8) addr = $urandom_range(32'h1000000, 32'h1FFFFFF);
      else             addr = bnd[$urandom_range(0, 5)];
      do_write(addr, 8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk_sys);
    end
    drain("random");
    check("random_overrun", 64'(overrun), 64'(exp_ovr));

    // End of download: rom_loaded, then the delayed second reset pulse.
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("rom_loaded_early", 64'(rom_loaded), 64'd0);
    got_v = '0;
    exp_v = '0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk_sys);
      if (n == 0) check("rom_loaded_set", 64'(rom_loaded), 64'd1);
      got_v[n] = core_reset;
      exp_v[n] = (n < 1) || (n == 1 + RC - 1);
    end
    check("load_core_reset_seq", 64'(got_v), 64'(exp_v));

    // User reset pulse of k cycles after load.
    k = 3;
    got_v = '0;
    exp_v = '0;
    @(posedge clk_sys); #1;
    user_reset = 1'b1;
    @(posedge clk_sys);
    for (int n = 0; n < k + RC + 5; n++) begin
      @(negedge clk_sys);
      got_v[n] = core_reset;
      exp_v[n] = (n < k) || (n == k + RC - 1);
      if (n == k - 1) user_reset = 1'b0;
    end
    check("user_core_reset_seq", 64'(got_v), 64'(exp_v));
    check("user_rom_loaded", 64'(rom_loaded), 64'd1);

    // Strobes outside a download are ignored.
    a_snap = port_a;
    for (int i = 0; i < 4; i++) do_write($urandom_range(0, 32'h1FFFFF), 8'($urandom));
    repeat (3) @(negedge clk_sys);
    check("nodl_a", 64'(port_a), 64'(a_snap));
    check("nodl_req", 64'(port_req), 64'(exp_req));

    // Reset in the middle of a download.
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    hold = '1;
    do_write(32'h40, 8'h3C);
    @(posedge clk_sys); #1;
    reset = 1'b1;
    ioctl_download = 1'b0;
    port_ack = '0;
    hold = '0;
    model_clear();
    @(negedge clk_sys);
    check("mid_req", 64'(port_req), 64'd0);
    check("mid_a", 64'(port_a), 64'd0);
    check("mid_ds", 64'(port_ds), 64'd0);
    check("mid_d", 64'(port_d), 64'd0);
    check("mid_overrun", 64'(overrun), 64'd0);
    check("mid_rom_loaded", 64'(rom_loaded), 64'd0);
    check("mid_core_reset", 64'(core_reset), 64'd1);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (12) @(negedge clk_sys);
    check("post_rst_rom_loaded", 64'(rom_loaded), 64'd0);
    check("post_rst_core_reset", 64'(core_reset), 64'd1);

    // A fresh download completes the load again.
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) do_write($urandom_range(0, 32'h3FFFF), 8'($urandom));
    drain("reload");
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reload_rom_loaded", 64'(rom_loaded), 64'd1);
    check("final_overrun", 64'(overrun), 64'(exp_ovr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
